// File: rtl/out_port_fifo_if.sv
// ---------------------------------------------------------------------------
// out_port_fifo_if
// Bundles the output-port handshake between the processor (write side), the
// peripheral (read side) and the out_port_fifo.
//   i_wr_en / i_wr_data : one word enqueued per cycle while the strobe is high
//   o_full / o_afull    : status derived from the registered occupancy
//   o_out_valid / o_out_data / i_out_ready : first-word-fall-through drain
//   o_count             : occupancy 0..DEPTH
//   o_overflow / i_clr_ovf : sticky drop flag and its synchronous clear
// The slave modport is the FIFO's view; the master modport is the
// environment's view (processor plus peripheral).
// ---------------------------------------------------------------------------
interface out_port_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              i_wr_en;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_full;
  logic              o_afull;
  logic              o_out_valid;
  logic [DATA_W-1:0] o_out_data;
  logic              i_out_ready;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              i_clr_ovf;

  modport master (
    output i_wr_en, i_wr_data, i_out_ready, i_clr_ovf,
    input  o_full, o_afull, o_out_valid, o_out_data, o_count, o_overflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_out_ready, i_clr_ovf,
    output o_full, o_afull, o_out_valid, o_out_data, o_count, o_overflow
  );
endinterface

// File: rtl/out_port_fifo.sv
// ---------------------------------------------------------------------------
// out_port_fifo
// Queues the processor's 16-bit OUT-instruction writes and drains them to an
// external peripheral over a valid/ready handshake (first-word-fall-through).
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset; clears pointers, count, overflow
//          flag and every storage entry
//   bus  : out_port_fifo_if.slave carrying the write strobe/data, the drain
//          handshake, full/almost-full status, occupancy and overflow flag
// ---------------------------------------------------------------------------
module out_port_fifo #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_LVL = 6
) (
  input logic             clk,
  input logic             rst,
  out_port_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Status comes only from the registered count, so there is no
  // combinational path from the strobes to full/afull/count.
  assign full = (count_q == DEPTH_C);
  assign pop  = (count_q != '0) && bus.i_out_ready;
  // A pop in the same cycle frees a slot, so a write to a full FIFO
  // is still accepted when the peripheral drains at the same time.
  assign push = bus.i_wr_en && (!full || pop);
  assign drop = bus.i_wr_en && full && !pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop)               ovf_d = 1'b1;
    else if (bus.i_clr_ovf) ovf_d = 1'b0;
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is cleared on reset so the head word reads zero straight away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.i_wr_data;
    end
  end

  assign bus.o_out_data  = mem_q[rd_ptr_q];
  assign bus.o_out_valid = (count_q != '0);
  assign bus.o_full      = full;
  assign bus.o_afull     = (count_q >= AFULL_C);
  assign bus.o_count     = count_q;
  assign bus.o_overflow  = ovf_q;

endmodule
